// File: rtl/fb_scanout_pkg.sv
// Shared defaults and helpers for the framebuffer scan-out slice.
// Latency: n/a (no logic).
// Backpressure: n/a.
package fb_scanout_pkg;

    localparam int DEF_CORDW     = 16;
    localparam int DEF_FB_WIDTH  = 160;
    localparam int DEF_FB_HEIGHT = 120;
    localparam int DEF_SCALE     = 4;
    localparam int DEF_DATAW     = 4;
    localparam int DEF_RD_LAT    = 1;

    // $clog2 that never returns zero, so a degenerate size still yields a 1-bit field
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Bundle of timing-generator inputs, framebuffer read port and display outputs.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a per-pixel-clock strobe or level.
interface fb_scanout_if
    import fb_scanout_pkg::*;
#(
    parameter int CORDW = DEF_CORDW,
    parameter int DATAW = DEF_DATAW,
    parameter int ADDRW = clog2_min1(DEF_FB_WIDTH * DEF_FB_HEIGHT)
);
    // timing generator side
    logic signed [CORDW-1:0] sx;
    logic signed [CORDW-1:0] sy;
    logic                    de;
    logic                    frame;
    logic                    line;
    logic                    hsync;
    logic                    vsync;
    // framebuffer read port
    logic                    fb_rd_en;
    logic [ADDRW-1:0]        fb_addr;
    logic [DATAW-1:0]        fb_data;
    // display side
    logic                    o_hsync;
    logic                    o_vsync;
    logic                    o_de;
    logic [DATAW-1:0]        o_pix;

    modport dut (
        input  sx, sy, de, frame, line, hsync, vsync, fb_data,
        output fb_rd_en, fb_addr, o_hsync, o_vsync, o_de, o_pix
    );

    modport tb (
        output sx, sy, de, frame, line, hsync, vsync, fb_data,
        input  fb_rd_en, fb_addr, o_hsync, o_vsync, o_de, o_pix
    );
endinterface

// File: rtl/fb_scanout_signal_delay.sv
// Fixed-depth shift register used to align side-band signals with memory data.
// Latency: DEPTH cycles.
// Backpressure: none; shifts every cycle, synchronous reset flushes all stages to 0.
module signal_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // shift one stage per cycle; reset clears the whole line so no stale values leak out
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dat_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: scaled read-address generation plus sync/de realignment to the read data.
// Latency: RD_LAT+2 cycles from timing inputs to o_hsync/o_vsync/o_de/o_pix.
// Backpressure: none; one pixel per clock, memory must honour the fixed read latency.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int CORDW     = DEF_CORDW,
    parameter int FB_WIDTH  = DEF_FB_WIDTH,
    parameter int FB_HEIGHT = DEF_FB_HEIGHT,
    parameter int SCALE     = DEF_SCALE,
    parameter int DATAW     = DEF_DATAW,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int BG_COLR   = 0
) (
    input  logic      clk_pix,
    input  logic      rst_pix,
    fb_scanout_if.dut bus
);

    localparam int ADDRW = clog2_min1(FB_WIDTH * FB_HEIGHT);
    localparam int CNTW  = clog2_min1(SCALE);
    localparam int LAT   = RD_LAT + 2;

    localparam logic signed [CORDW-1:0] X_LIM    = CORDW'(FB_WIDTH * SCALE);
    localparam logic signed [CORDW-1:0] Y_LIM    = CORDW'(FB_HEIGHT * SCALE);
    localparam logic [CNTW-1:0]         CNT_LAST = CNTW'(SCALE - 1);
    localparam logic [ADDRW-1:0]        ROW_STEP = ADDRW'(FB_WIDTH);
    localparam logic [DATAW-1:0]        BG       = DATAW'(BG_COLR);

    logic             synced_q;
    logic [ADDRW-1:0] line_base_q, line_base_d;
    logic [ADDRW-1:0] pix_addr_q, pix_addr_d;
    logic [CNTW-1:0]  hcnt_q, hcnt_d;
    logic [CNTW-1:0]  vcnt_q, vcnt_d;
    logic             row_used_q, row_used_d;
    logic             rd_en_q;
    logic [ADDRW-1:0] rd_addr_q;
    logic [DATAW-1:0] pix_q;
    logic             inreg;
    logic             rd_go;
    logic             rd_go_dly;
    logic [2:0]       sync_dly;

    // de already implies a non-negative position; the sign checks only guard odd generators
    assign inreg = bus.de && !bus.sx[CORDW-1] && !bus.sy[CORDW-1] &&
                   (bus.sx < X_LIM) && (bus.sy < Y_LIM);
    assign rd_go = inreg && synced_q;

    // address walk: frame rewinds, line steps the row base after SCALE used lines, pixels step every SCALE reads
    always_comb begin
        line_base_d = line_base_q;
        pix_addr_d  = pix_addr_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        row_used_d  = row_used_q;
        if (bus.frame) begin
            line_base_d = '0;
            pix_addr_d  = '0;
            hcnt_d      = '0;
            vcnt_d      = '0;
            row_used_d  = 1'b0;
        end else if (bus.line) begin
            // blank lines never set row_used, so they do not consume vertical repeats
            if (row_used_q) begin
                if (vcnt_q == CNT_LAST) begin
                    vcnt_d      = '0;
                    line_base_d = line_base_q + ROW_STEP;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end
            pix_addr_d = line_base_d;
            hcnt_d     = '0;
            row_used_d = 1'b0;
        end else if (rd_go) begin
            row_used_d = 1'b1;
            if (hcnt_q == CNT_LAST) begin
                hcnt_d     = '0;
                pix_addr_d = pix_addr_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // state registers and the registered read port; address holds between reads
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            synced_q    <= 1'b0;
            line_base_q <= '0;
            pix_addr_q  <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            row_used_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            synced_q    <= synced_q | bus.frame;
            line_base_q <= line_base_d;
            pix_addr_q  <= pix_addr_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            row_used_q  <= row_used_d;
            rd_en_q     <= rd_go;
            if (rd_go) begin
                rd_addr_q <= pix_addr_q;
            end
        end
    end

    signal_delay #(.WIDTH(3), .DEPTH(LAT)) u_sync_dly (
        .clk_i (clk_pix),
        .rst_i (rst_pix),
        .dat_i ({bus.hsync, bus.vsync, bus.de}),
        .dat_o (sync_dly)
    );

    // one stage shorter than the sync path: it meets fb_data, then both go through pix_q
    signal_delay #(.WIDTH(1), .DEPTH(LAT - 1)) u_reg_dly (
        .clk_i (clk_pix),
        .rst_i (rst_pix),
        .dat_i (rd_go),
        .dat_o (rd_go_dly)
    );

    // output pixel: memory data inside the bitmap, background elsewhere, 0 while in reset
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            pix_q <= '0;
        end else begin
            pix_q <= rd_go_dly ? bus.fb_data : BG;
        end
    end

    assign bus.fb_rd_en = rd_en_q;
    assign bus.fb_addr  = rd_addr_q;
    assign bus.o_hsync  = sync_dly[2];
    assign bus.o_vsync  = sync_dly[1];
    assign bus.o_de     = sync_dly[0];
    assign bus.o_pix    = pix_q;

endmodule
